// File: rtl/mdu_seq_if.sv
// Request/response bundle between an issuing pipeline and the sequential mul/div unit.
interface mdu_seq_if #(
  parameter int WIDTH = 32
);
  // Handshake: a request is taken at a rising edge when start=1, cancel=0 and busy=0;
  // the issuer must stall on start|busy because requests seen while busy are dropped, not queued.
  // done pulses for one cycle when a multi-cycle result lands in hi/lo.
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             dbg_state;

  modport master (
    output start, op, a, b, cancel,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu_seq.sv
// Sequential HI/LO multiply-divide unit with fixed-latency busy window.
// Define MDU_SEQ_MADD_EN to compile in the MADD/MSUB accumulate operations.
module mdu_seq #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_seq_if.slave   bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             done_q;

  logic             is_mul, is_div, accept, finish;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic             div_signed, neg_a, neg_b;
  logic [WIDTH-1:0] dvd, dvs, quo, rem;
  logic             res_wr;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_SEQ_MADD_EN
    is_mul = is_mul || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`endif
    is_div = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    accept = bus.start && !bus.cancel && (state == IDLE);
    finish = (state == BUSY) && (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (is_mul || is_div)) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed divide runs on magnitudes; a zero divisor is replaced so the divider never sees it.
  always_comb begin
    prod_s     = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    div_signed = (op_q == OP_DIV);
    neg_a      = div_signed && a_q[WIDTH-1];
    neg_b      = div_signed && b_q[WIDTH-1];
    dvd        = neg_a ? -a_q : a_q;
    dvs        = (b_q == '0) ? WIDTH'(1) : (neg_b ? -b_q : b_q);
    quo        = dvd / dvs;
    rem        = dvd % dvs;
    if (neg_a ^ neg_b) quo = -quo;
    if (neg_a)         rem = -rem;

    res_wr = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT:  begin res_wr = 1'b1; {res_hi, res_lo} = prod_s; end
      OP_MULTU: begin res_wr = 1'b1; {res_hi, res_lo} = prod_u; end
      OP_DIV, OP_DIVU: begin
        if (b_q != '0) begin
          res_wr = 1'b1;
          res_hi = rem;
          res_lo = quo;
        end
      end
`ifdef MDU_SEQ_MADD_EN
      OP_MADD:  begin res_wr = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} + prod_s; end
      OP_MSUB:  begin res_wr = 1'b1; {res_hi, res_lo} = {hi_q, lo_q} - prod_s; end
`endif
      default:  res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept && (is_mul || is_div)) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
        cnt  <= is_div ? DIV_N : MULT_N;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (accept && (bus.op == OP_MTHI)) hi_q <= bus.a;
      if (accept && (bus.op == OP_MTLO)) lo_q <= bus.a;
      if (finish && res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy      = (state == BUSY);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus randomized bench for mdu_seq against an arithmetic reference of HI/LO.
module tb_mdu_seq;
  localparam int W      = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [W-1:0] m_hi, m_lo;
  logic [W-1:0] exp_q[$];

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag);
    logic [W-1:0] eh, el;
    eh = exp_q.pop_front();
    el = exp_q.pop_front();
    check({tag, "_hi"}, 64'(bus.hi), 64'(eh));
    check({tag, "_lo"}, 64'(bus.lo), 64'(el));
  endtask

  // reference model: HI/LO as a 64-bit pair updated with plain arithmetic
  function automatic int op_latency(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MULT_N;
      3'd2, 3'd3: return DIV_N;
      3'd4, 3'd5: return 0;
`ifdef MDU_SEQ_MADD_EN
      default:    return MULT_N;
`else
      default:    return -1;
`endif
    endcase
  endfunction

  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: {m_hi, m_lo} = 64'(sa * sb);
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
      3'd2: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      3'd6: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
      default: {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
    endcase
    exp_q.push_back(m_hi);
    exp_q.push_back(m_lo);
  endtask

  // driver: issue one request and follow it to completion
  task automatic do_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cxl);
    int lat, cnt;
    lat = cxl ? -1 : op_latency(op);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.cancel = cxl;
    step();
    bus.start = 1'b0; bus.cancel = 1'b0;
    if (lat >= 0) model_op(op, a, b);
    else begin exp_q.push_back(m_hi); exp_q.push_back(m_lo); end
    if (lat <= 0) begin
      check({tag, "_nobusy"}, 64'(bus.busy), 64'(0));
      check({tag, "_nodone"}, 64'(bus.done), 64'(0));
      check_hilo(tag);
      step();
      check({tag, "_nobusy2"}, 64'(bus.busy), 64'(0));
    end else begin
      cnt = 0;
      while (bus.busy === 1'b1 && cnt <= lat + 2) begin
        if (bus.done !== 1'b0) check({tag, "_early_done"}, 64'(bus.done), 64'(0));
        bus.a = $urandom;
        bus.b = $urandom;
        bus.cancel = 1'($urandom_range(0, 1));
        step();
        cnt++;
      end
      bus.cancel = 1'b0;
      check({tag, "_busy_len"}, 64'(cnt), 64'(lat));
      check({tag, "_done"}, 64'(bus.done), 64'(1));
      check_hilo(tag);
      step();
      check({tag, "_done_once"}, 64'(bus.done), 64'(0));
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    logic rc;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    apply_reset();
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_hi",   64'(bus.hi),   64'(0));
    check("rst_lo",   64'(bus.lo),   64'(0));

    do_op("mult_m2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    do_op("divu_7_2",  3'd3, 32'd7, 32'd2, 1'b0);
    do_op("div_m7_2",  3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op("mthi",      3'd4, 32'h1234_5678, 32'd0, 1'b0);
    do_op("div_by0",   3'd2, 32'd99, 32'd0, 1'b0);
    do_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // DIVU requested mid-MULT is dropped
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'hFFFF_FFF9;
    step();
    bus.start = 1'b0;
    model_op(3'd0, 32'd5, 32'hFFFF_FFF9);
    step(); step();
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    check("ign_busy_c4", 64'(bus.busy), 64'(1));
    step();
    check("ign_busy_c5", 64'(bus.busy), 64'(1));
    step();
    check("ign_busy_end", 64'(bus.busy), 64'(0));
    check("ign_done", 64'(bus.done), 64'(1));
    check_hilo("ign_mult");
    step();
    check("ign_not_queued", 64'(bus.busy), 64'(0));
    do_op("cancel_divu", 3'd3, 32'd100, 32'd7, 1'b1);

    // reset in the middle of a DIV
    bus.start = 1'b1; bus.op = 3'd2; bus.a = 32'd1000; bus.b = 32'd3;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    check("rstmid_busy", 64'(bus.busy), 64'(0));
    check("rstmid_done", 64'(bus.done), 64'(0));
    check("rstmid_hi",   64'(bus.hi),   64'(0));
    check("rstmid_lo",   64'(bus.lo),   64'(0));
    for (int i = 0; i < DIV_N + 2; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0)
        check("rstmid_quiet", {62'd0, bus.busy, bus.done}, 64'(0));
      step();
    end
    check("rstmid_hi_late", 64'(bus.hi), 64'(0));
    check("rstmid_lo_late", 64'(bus.lo), 64'(0));

    do_op("mtlo_ones", 3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op("madd_1x1",  3'd6, 32'd1, 32'd1, 1'b0);
    do_op("msub_3x4",  3'd7, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rc = ($urandom_range(0, 7) == 0);
      do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
